// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the readout stream arbiters.
// Holds the arbiter state enum and the rotating-priority pick.
package stream_arb_pkg;

    typedef enum logic {
        IDLE,
        XFER
    } arb_state_t;

    localparam int ARB_MAX_SRC = 32;
    localparam int ARB_IDX_W   = $clog2(ARB_MAX_SRC);

    // First set request after 'last', wrapping modulo n_src.
    function automatic int unsigned rr_pick(
        input logic [ARB_MAX_SRC-1:0] req,
        input int unsigned            n_src,
        input int unsigned            last
    );
        logic [ARB_MAX_SRC-1:0] rot;
        int unsigned            idx;
        int unsigned            win;
        logic                   hit;
        win = 0;
        hit = 1'b0;
        for (int unsigned k = 1; k <= ARB_MAX_SRC; k++) begin
            idx = (last + k) % n_src;
            rot = req >> idx;
            if (k <= n_src && !hit && rot[0]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/stream_arb_rr_pick.sv
// Combinational rotating-priority encoder.
// Search starts one past the last granted index.
module stream_arb_rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             found,
    output logic [ID_W-1:0]  winner
);

    logic [ARB_MAX_SRC-1:0] req_ext;
    int unsigned            pick;

    always_comb begin
        req_ext            = '0;
        req_ext[N_SRC-1:0] = req;
        pick   = rr_pick(req_ext, N_SRC, 32'(last));
        found  = |req;
        winner = ID_W'(pick);
    end

endmodule

// File: rtl/stream_burst_arbiter.sv
// Round-robin burst arbiter merging FWFT readout streams into one
// registered FIFO write port, with hold requests and hold timeout.
module stream_burst_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_SRC        = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [N_SRC-1:0]            SRC_EMPTY,
    input  logic [N_SRC-1:0]            SRC_HOLD,
    input  logic [N_SRC*DATA_WIDTH-1:0] SRC_DATA,
    output logic [N_SRC-1:0]            SRC_READ,
    input  logic                        OUT_FULL,
    output logic                        OUT_WRITE,
    output logic [DATA_WIDTH-1:0]       OUT_DATA,
    output logic                        GRANT_VALID,
    output logic [$clog2(N_SRC)-1:0]    GRANT_ID,
    output logic                        HOLD_TIMEOUT_ERR,
    output logic [31:0]                 WORD_COUNT
);

    localparam int ID_W = $clog2(N_SRC);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int HC_W = $clog2(HOLD_TIMEOUT + 1);

    localparam logic [BC_W-1:0] BURST_MAX  = BC_W'(MAX_BURST);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);
    localparam logic [HC_W-1:0] HOLD_MAX   = HC_W'(HOLD_TIMEOUT);
    localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_TIMEOUT - 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [ID_W-1:0]       last_grant;
    logic [ID_W-1:0]       win_id;
    logic                  found;
    logic [BC_W-1:0]       burst_cnt;
    logic [HC_W-1:0]       hold_cnt;
    logic [DATA_WIDTH-1:0] word;
    logic                  xfer;
    logic                  rd;
    logic                  empty_g;
    logic                  hold_g;
    logic                  idle_hold;
    logic                  rel_burst;
    logic                  rel_drain;
    logic                  rel_tmo;
    logic                  rel;

    stream_arb_rr_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (~SRC_EMPTY),
        .last   (last_grant),
        .found  (found),
        .winner (win_id)
    );

    always_comb begin
        xfer    = (state == XFER);
        empty_g = SRC_EMPTY[GRANT_ID];
        hold_g  = SRC_HOLD[GRANT_ID];
        word    = SRC_DATA[GRANT_ID*DATA_WIDTH +: DATA_WIDTH];
        rd      = xfer && !empty_g && !OUT_FULL;

        SRC_READ           = '0;
        SRC_READ[GRANT_ID] = rd;

        // Release checks include the read happening this cycle.
        idle_hold = xfer && empty_g && hold_g;
        rel_burst = rd && !hold_g && (burst_cnt >= BURST_LAST);
        rel_drain = xfer && empty_g && !hold_g;
        rel_tmo   = idle_hold && (hold_cnt >= HOLD_LAST);
        rel       = rel_burst || rel_drain || rel_tmo;

        HOLD_TIMEOUT_ERR = rel_tmo;
        GRANT_VALID      = xfer;

        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = XFER;
            XFER:    if (rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            GRANT_ID   <= '0;
            last_grant <= ID_W'(N_SRC - 1);
            burst_cnt  <= '0;
            hold_cnt   <= '0;
            OUT_WRITE  <= 1'b0;
            OUT_DATA   <= '0;
            WORD_COUNT <= '0;
        end else begin
            OUT_WRITE <= rd;
            if (!xfer && found) begin
                GRANT_ID  <= win_id;
                burst_cnt <= '0;
                hold_cnt  <= '0;
            end
            if (rd) begin
                OUT_DATA   <= word;
                WORD_COUNT <= WORD_COUNT + 32'd1;
                hold_cnt   <= '0;
                if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else if (idle_hold && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (rel) last_grant <= GRANT_ID;
        end
    end

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Directed bench for stream_burst_arbiter: latency, fairness, hold,
// timeout, backpressure and mid-burst reset.
module tb_stream_burst_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  SRC_EMPTY;
    logic [1:0]  SRC_HOLD;
    logic [63:0] SRC_DATA;
    logic [1:0]  SRC_READ;
    logic        OUT_FULL;
    logic        OUT_WRITE;
    logic [31:0] OUT_DATA;
    logic        GRANT_VALID;
    logic [0:0]  GRANT_ID;
    logic        HOLD_TIMEOUT_ERR;
    logic [31:0] WORD_COUNT;

    stream_burst_arbiter #(
        .N_SRC        (2),
        .DATA_WIDTH   (32),
        .MAX_BURST    (4),
        .HOLD_TIMEOUT (8)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .SRC_EMPTY        (SRC_EMPTY),
        .SRC_HOLD         (SRC_HOLD),
        .SRC_DATA         (SRC_DATA),
        .SRC_READ         (SRC_READ),
        .OUT_FULL         (OUT_FULL),
        .OUT_WRITE        (OUT_WRITE),
        .OUT_DATA         (OUT_DATA),
        .GRANT_VALID      (GRANT_VALID),
        .GRANT_ID         (GRANT_ID),
        .HOLD_TIMEOUT_ERR (HOLD_TIMEOUT_ERR),
        .WORD_COUNT       (WORD_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          total;
    int          bad;
    int          cyc;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] out_q[$];
    int          wcyc[$];
    logic [1:0]  rd_s;
    logic        gv_s;
    logic        gv_prev;
    logic [0:0]  gid_s;
    logic        err_s;
    logic        full_s;
    logic        bp_en;
    int          err_cnt;
    int          grants;
    int          gid_bad;
    int          bp_viol;
    int          gsrc[6];
    int          gbase[6];
    int          glen[6];
    int          ggap[6];
    int          p;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [31:0] d);
        if (s == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic drive();
        SRC_EMPTY[0]     = (q0.size() == 0);
        SRC_EMPTY[1]     = (q1.size() == 0);
        SRC_DATA[31:0]   = (q0.size() != 0) ? q0[0] : 32'h0;
        SRC_DATA[63:32]  = (q1.size() != 0) ? q1[0] : 32'h0;
        OUT_FULL         = bp_en && cyc[1];
    endtask

    // Sample combinational outputs mid-cycle, then pop/log after the edge.
    task automatic step();
        @(negedge CLK);
        rd_s   = SRC_READ;
        gv_s   = GRANT_VALID;
        gid_s  = GRANT_ID;
        err_s  = HOLD_TIMEOUT_ERR;
        full_s = OUT_FULL;
        if (err_s) err_cnt++;
        if (gv_s && !gv_prev) grants++;
        if (gv_s && gid_s != 1'b0) gid_bad++;
        if (full_s && rd_s != 2'b00) bp_viol++;
        gv_prev = gv_s;
        @(posedge CLK);
        #1;
        cyc++;
        if (rd_s[0] && q0.size() != 0) void'(q0.pop_front());
        if (rd_s[1] && q1.size() != 0) void'(q1.pop_front());
        if (OUT_WRITE) begin
            out_q.push_back(OUT_DATA);
            wcyc.push_back(cyc);
        end
        drive();
    endtask

    task automatic run_until(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < limit) begin
            step();
            k++;
        end
        chk(tag, 32'(out_q.size()), 32'(n));
    endtask

    task automatic clear_log();
        out_q.delete();
        wcyc.delete();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        err_cnt  = 0;
        grants   = 0;
        gid_bad  = 0;
        bp_viol  = 0;
        gv_prev  = 1'b0;
        bp_en    = 1'b0;
        RST_N    = 1'b0;
        SRC_HOLD = 2'b00;
        drive();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_write", 32'(OUT_WRITE), 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_gv", 32'(GRANT_VALID), 0);
        chk("rst_gid", 32'(GRANT_ID), 0);
        chk("rst_read", 32'(SRC_READ), 0);
        chk("rst_err", 32'(HOLD_TIMEOUT_ERR), 0);
        chk("rst_wc", WORD_COUNT, 0);
        RST_N = 1'b1;

        // Latency: one word on src1
        push(1, 32'hDEADBEEF);
        drive();
        step();
        chk("lat_gv_t", 32'(gv_s), 0);
        chk("lat_gv_t1", 32'(GRANT_VALID), 1);
        chk("lat_gid_t1", 32'(GRANT_ID), 1);
        chk("lat_wr_t1", 32'(OUT_WRITE), 0);
        step();
        chk("lat_read_t1", 32'(rd_s), 32'h2);
        chk("lat_wr_t2", 32'(OUT_WRITE), 1);
        chk("lat_data_t2", OUT_DATA, 32'hDEADBEEF);
        chk("lat_wc", WORD_COUNT, 1);
        step();
        chk("lat_release", 32'(GRANT_VALID), 0);
        clear_log();

        // Fairness: 10 words each, no hold
        for (int k = 0; k < 10; k++) begin
            push(0, 32'hA000_0000 + 32'(k));
            push(1, 32'hB000_0000 + 32'(k));
        end
        drive();
        run_until(20, 80, "fair_cnt");
        gsrc  = '{0, 1, 0, 1, 0, 1};
        gbase = '{0, 0, 4, 4, 8, 8};
        glen  = '{4, 4, 4, 4, 2, 2};
        ggap  = '{2, 2, 2, 2, 3, 0};
        p = 0;
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < glen[j]; k++) begin
                chk($sformatf("fair_d%0d", p), out_q[p],
                    (gsrc[j] == 0 ? 32'hA000_0000 : 32'hB000_0000)
                    + 32'(gbase[j] + k));
                if (k > 0)
                    chk($sformatf("fair_gap%0d", p),
                        32'(wcyc[p] - wcyc[p-1]), 1);
                else if (j > 0)
                    chk($sformatf("fair_gap%0d", p),
                        32'(wcyc[p] - wcyc[p-1]), 32'(ggap[j-1]));
                p++;
            end
        end
        repeat (3) step();
        chk("fair_wc", WORD_COUNT, 21);
        clear_log();

        // Hold: 7-word event on src1 with a 3-cycle gap, src0 waiting
        SRC_HOLD = 2'b10;
        for (int k = 0; k < 3; k++) push(1, 32'hC000_0000 + 32'(k));
        drive();
        step();
        chk("hold_gid", 32'(GRANT_ID), 1);
        push(0, 32'hD000_0000);
        push(0, 32'hD000_0001);
        drive();
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold_gap_gv%0d", k), 32'(gv_s), 1);
            chk($sformatf("hold_gap_rd%0d", k), 32'(rd_s), 0);
        end
        for (int k = 3; k < 7; k++) push(1, 32'hC000_0000 + 32'(k));
        drive();
        repeat (4) step();
        SRC_HOLD = 2'b00;
        drive();
        run_until(9, 30, "hold_cnt");
        for (int k = 0; k < 7; k++)
            chk($sformatf("hold_d%0d", k), out_q[k], 32'hC000_0000 + 32'(k));
        chk("hold_d7", out_q[7], 32'hD000_0000);
        chk("hold_d8", out_q[8], 32'hD000_0001);
        chk("hold_gap_len", 32'(wcyc[3] - wcyc[2]), 4);
        chk("hold_to_src0", 32'(wcyc[7] - wcyc[6]), 3);
        repeat (2) step();
        clear_log();

        // Timeout: src0 held and empty
        SRC_HOLD = 2'b01;
        err_cnt  = 0;
        push(0, 32'hE000_0000);
        drive();
        step();
        chk("tmo_gid0", 32'(GRANT_ID), 0);
        push(1, 32'hF000_0000);
        push(1, 32'hF000_0001);
        drive();
        step();
        chk("tmo_read", 32'(rd_s), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("tmo_err_c%0d", k), 32'(err_s), 32'(k == 8));
        end
        chk("tmo_released", 32'(GRANT_VALID), 0);
        step();
        chk("tmo_regrant_gv", 32'(GRANT_VALID), 1);
        chk("tmo_regrant_gid", 32'(GRANT_ID), 1);
        chk("tmo_err_pulses", 32'(err_cnt), 1);
        SRC_HOLD = 2'b00;
        drive();
        run_until(3, 20, "tmo_cnt");
        chk("tmo_d1", out_q[1], 32'hF000_0000);
        chk("tmo_d2", out_q[2], 32'hF000_0001);
        repeat (2) step();
        clear_log();

        // Backpressure: 16 words on src0, OUT_FULL toggling every 2 cycles
        grants  = 0;
        gid_bad = 0;
        bp_viol = 0;
        bp_en   = 1'b1;
        for (int k = 0; k < 16; k++) push(0, 32'h5000_0000 + 32'(k));
        drive();
        run_until(16, 120, "bp_cnt");
        bp_en = 1'b0;
        drive();
        repeat (3) step();
        for (int k = 0; k < 16; k++)
            chk($sformatf("bp_d%0d", k), out_q[k], 32'h5000_0000 + 32'(k));
        chk("bp_extra", 32'(out_q.size()), 16);
        chk("bp_grants", 32'(grants), 4);
        chk("bp_gid", 32'(gid_bad), 0);
        chk("bp_read_full", 32'(bp_viol), 0);
        chk("bp_wc", WORD_COUNT, 49);
        clear_log();

        // Reset mid-burst, then priority restart at src0
        for (int k = 0; k < 6; k++) push(1, 32'h7000_0000 + 32'(k));
        drive();
        repeat (3) step();
        chk("mid_pre_wr", 32'(OUT_WRITE), 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_wr", 32'(OUT_WRITE), 0);
        chk("mid_data", OUT_DATA, 0);
        chk("mid_gv", 32'(GRANT_VALID), 0);
        chk("mid_gid", 32'(GRANT_ID), 0);
        chk("mid_read", 32'(SRC_READ), 0);
        chk("mid_wc", WORD_COUNT, 0);
        q0.delete();
        q1.delete();
        push(0, 32'h9000_0000);
        push(1, 32'h9100_0000);
        drive();
        step();
        RST_N = 1'b1;
        clear_log();
        run_until(2, 20, "post_rst_cnt");
        chk("post_rst_first", out_q[0], 32'h9000_0000);
        chk("post_rst_second", out_q[1], 32'h9100_0000);
        chk("post_rst_wc", WORD_COUNT, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
